sad_pe_param: RTL and testbench

SAD_PE_PARAM -- requirements
Module: sad_pe_param

---
 rtl/sad_pe_param.sv | 209 ++++++++++++++++++++
 tb/tb_sad_pe_param.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_pe_param.sv
// rtl/sad_pe_param.sv - Pipelined N x N SAD processing element; optional min tracker under SAD_MIN_TRACK_EN
module sad_pe_param #(
  parameter int N     = 8,
  parameter int PW    = 8,
  parameter int SAD_W = 14,
  parameter int NCAND = 16,
  localparam int LN   = $clog2(N),
  localparam int IW   = (NCAND > 1) ? $clog2(NCAND) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cur_we,
  input  logic [LN-1:0]    cur_addr,
  input  logic [N*PW-1:0]  cur_data,
  input  logic             start,
  input  logic             ref_valid,
  output logic             ref_ready,
  input  logic [N*PW-1:0]  ref_data,
  output logic             sad_valid,
  output logic [SAD_W-1:0] sad,
  output logic [IW-1:0]    sad_idx,
  output logic [SAD_W-1:0] best_sad,
  output logic [IW-1:0]    best_idx,
  output logic             done
);

  localparam logic [LN-1:0] ROW_LAST  = LN'(N - 1);
  localparam logic [IW-1:0] CAND_LAST = IW'(NCAND - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [N*PW-1:0]  cur_mem [N];
  logic [N*PW-1:0]  cur_row;
  logic [LN-1:0]    row_cnt;
  logic [IW-1:0]    cand_cnt;
  logic             accept;
  logic             start_ok;

  logic [PW-1:0]    diff_c  [N];
  logic [PW-1:0]    s1_diff [N];
  logic             s1_valid;
  logic             s1_first;
  logic             s1_last;
  logic [IW-1:0]    s1_idx;

  logic [SAD_W-1:0] row_sum_c;
  logic [SAD_W-1:0] s2_sum;
  logic             s2_valid;
  logic             s2_first;
  logic             s2_last;
  logic [IW-1:0]    s2_idx;

  logic [SAD_W-1:0] acc;
  logic [SAD_W-1:0] acc_sum;

  assign accept   = ref_valid & ref_ready;
  assign start_ok = start & (state == IDLE);
  assign cur_row  = cur_mem[row_cnt];

  // Current-block storage: writable only while idle so a running search sees a stable block
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) cur_mem[i] <= '0;
    end else if (cur_we && state == IDLE) begin
      cur_mem[cur_addr] <= cur_data;
    end
  end

  // Search sequencer: state, row/candidate counters, ref_ready and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ref_ready <= 1'b0;
      done      <= 1'b0;
      row_cnt   <= '0;
      cand_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            ref_ready <= 1'b1;
            row_cnt   <= '0;
            cand_cnt  <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            if (row_cnt == ROW_LAST) begin
              row_cnt <= '0;
              if (cand_cnt == CAND_LAST) begin
                state     <= DRAIN;
                ref_ready <= 1'b0;
              end else begin
                cand_cnt <= cand_cnt + 1'b1;
              end
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (sad_valid && sad_idx == CAND_LAST) state <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-pixel absolute differences between the addressed current row and the incoming beat
  always_comb begin
    for (int i = 0; i < N; i++) begin
      if (cur_row[i*PW +: PW] > ref_data[i*PW +: PW])
        diff_c[i] = cur_row[i*PW +: PW] - ref_data[i*PW +: PW];
      else
        diff_c[i] = ref_data[i*PW +: PW] - cur_row[i*PW +: PW];
    end
  end

  // Stage 1: register the differences with row-position tags
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_idx   <= '0;
      for (int i = 0; i < N; i++) s1_diff[i] <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_diff  <= diff_c;
        s1_first <= (row_cnt == '0);
        s1_last  <= (row_cnt == ROW_LAST);
        s1_idx   <= cand_cnt;
      end
    end
  end

  // Row sum of the registered differences
  always_comb begin
    row_sum_c = '0;
    for (int i = 0; i < N; i++) row_sum_c = row_sum_c + SAD_W'(s1_diff[i]);
  end

  // Stage 2: register the row sum
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_idx   <= '0;
      s2_sum   <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sum   <= row_sum_c;
        s2_first <= s1_first;
        s2_last  <= s1_last;
        s2_idx   <= s1_idx;
      end
    end
  end

  // Row 0 restarts the accumulation so consecutive candidates need no bubble
  assign acc_sum = s2_first ? s2_sum : acc + s2_sum;

  // Stage 3: accumulate rows and publish the candidate SAD after its last row
  always_ff @(posedge clk) begin
    if (rst) begin
      sad_valid <= 1'b0;
      sad       <= '0;
      sad_idx   <= '0;
      acc       <= '0;
    end else begin
      sad_valid <= s2_valid & s2_last;
      if (start_ok)
        acc <= '0;
      else if (s2_valid)
        acc <= acc_sum;
      if (s2_valid && s2_last) begin
        sad     <= acc_sum;
        sad_idx <= s2_idx;
      end
    end
  end

`ifdef SAD_MIN_TRACK_EN
  // Minimum tracker: strict less-than so ties keep the earlier candidate
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      best_sad <= '1;
      best_idx <= '0;
    end else if (s2_valid && s2_last && acc_sum < best_sad) begin
      best_sad <= acc_sum;
      best_idx <= s2_idx;
    end
  end
`else
  assign best_sad = '0;
  assign best_idx = '0;
`endif

endmodule

// File: tb/tb_sad_pe_param.sv
// tb/tb_sad_pe_param.sv - Directed self-checking bench for sad_pe_param with a cycle-indexed reference model
module tb_sad_pe_param;
  localparam int N     = 8;
  localparam int PW    = 8;
  localparam int SAD_W = 14;
  localparam int NCAND = 4;
  localparam int IW    = 2;
`ifdef SAD_MIN_TRACK_EN
  localparam int BEST_INIT = (1 << SAD_W) - 1;
`else
  localparam int BEST_INIT = 0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cur_we = 1'b0;
  logic [2:0]       cur_addr = '0;
  logic [N*PW-1:0]  cur_data = '0;
  logic             start = 1'b0;
  logic             ref_valid = 1'b0;
  logic             ref_ready;
  logic [N*PW-1:0]  ref_data = '0;
  logic             sad_valid;
  logic [SAD_W-1:0] sad;
  logic [IW-1:0]    sad_idx;
  logic [SAD_W-1:0] best_sad;
  logic [IW-1:0]    best_idx;
  logic             done;

  sad_pe_param #(.N(N), .PW(PW), .SAD_W(SAD_W), .NCAND(NCAND)) dut (
    .clk(clk), .rst(rst), .cur_we(cur_we), .cur_addr(cur_addr), .cur_data(cur_data),
    .start(start), .ref_valid(ref_valid), .ref_ready(ref_ready), .ref_data(ref_data),
    .sad_valid(sad_valid), .sad(sad), .sad_idx(sad_idx),
    .best_sad(best_sad), .best_idx(best_idx), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Model data: pixel arrays and the block the DUT is expected to hold
  int cur_px   [N][N];
  int cur_model[N][N];
  int ref_px   [NCAND][N][N];

  // Expectations keyed by the cycle in which they must be visible
  int exp_sad [int];
  int exp_idx [int];
  bit exp_done[int];
  bit exp_clr [int];
  bit exp_rst [int];

  function automatic int cand_sad(input int c);
    int s = 0;
    for (int r = 0; r < N; r++)
      for (int p = 0; p < N; p++)
        s += (cur_model[r][p] > ref_px[c][r][p]) ? cur_model[r][p] - ref_px[c][r][p]
                                                 : ref_px[c][r][p] - cur_model[r][p];
    return s;
  endfunction

  function automatic logic [N*PW-1:0] pack_cur(input int r);
    logic [N*PW-1:0] v;
    for (int p = 0; p < N; p++) v[p*PW +: PW] = PW'(cur_px[r][p]);
    return v;
  endfunction

  function automatic logic [N*PW-1:0] pack_ref(input int c, input int r);
    logic [N*PW-1:0] v;
    for (int p = 0; p < N; p++) v[p*PW +: PW] = PW'(ref_px[c][r][p]);
    return v;
  endfunction

  // Compare process: checks every output every cycle against the model expectations
  bit chk_en = 1'b0;
  int m_sad = 0;
  int m_idx = 0;
  int m_best = BEST_INIT;
  int m_bidx = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_rst.exists(cyc)) begin
        m_sad = 0; m_idx = 0; m_best = BEST_INIT; m_bidx = 0;
      end
      if (exp_clr.exists(cyc)) begin
        m_best = BEST_INIT; m_bidx = 0;
      end
      if (exp_sad.exists(cyc)) begin
        check("sad_valid pulse", sad_valid, 1);
        check("sad value", sad, exp_sad[cyc]);
        check("sad_idx value", sad_idx, exp_idx[cyc]);
        m_sad = exp_sad[cyc];
        m_idx = exp_idx[cyc];
`ifdef SAD_MIN_TRACK_EN
        if (m_sad < m_best) begin
          m_best = m_sad; m_bidx = m_idx;
        end
`endif
      end else begin
        check("sad_valid quiet", sad_valid, 0);
        check("sad hold", sad, m_sad);
        check("sad_idx hold", sad_idx, m_idx);
      end
      check("done timing", done, exp_done.exists(cyc) ? 1 : 0);
      check("best_sad", best_sad, m_best);
      check("best_idx", best_idx, m_bidx);
    end
  end

  task automatic fill_cur(input int v);
    for (int r = 0; r < N; r++) for (int p = 0; p < N; p++) cur_px[r][p] = v;
  endtask

  task automatic fill_ref(input int v);
    for (int c = 0; c < NCAND; c++)
      for (int r = 0; r < N; r++) for (int p = 0; p < N; p++) ref_px[c][r][p] = v;
  endtask

  task automatic fill_ref_target(input int c, input int target);
    int rem = target;
    for (int r = 0; r < N; r++)
      for (int p = 0; p < N; p++) begin
        ref_px[c][r][p] = (rem > 255) ? 255 : rem;
        rem -= ref_px[c][r][p];
      end
  endtask

  task automatic write_block();
    for (int r = 0; r < N; r++) begin
      cur_we = 1'b1; cur_addr = 3'(r); cur_data = pack_cur(r);
      for (int p = 0; p < N; p++) cur_model[r][p] = cur_px[r][p];
      @(negedge clk);
    end
    cur_we = 1'b0;
  endtask

  // mode 0: continuous ref_valid, mode 1: alternating; inject pokes cur_we/start mid-run
  task automatic run_search(input int mode, input bit inject, input int nbeats);
    int beat = 0;
    int budget = 0;
    bit v;
    logic [N*PW-1:0] ones = '1;
    start = 1'b1;
    exp_clr[cyc + 1] = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (beat < nbeats && budget < 2000) begin
      v = (mode == 0) ? 1'b1 : (budget % 2 == 0);
      ref_valid = v;
      ref_data  = pack_ref(beat / N, beat % N);
      if (inject && beat == 3) begin
        cur_we = 1'b1; cur_addr = '0; cur_data = ones; start = 1'b1;
      end else begin
        cur_we = 1'b0; start = 1'b0;
      end
      if (v && ref_ready) begin
        if (beat % N == N - 1) begin
          exp_sad[cyc + 3] = cand_sad(beat / N);
          exp_idx[cyc + 3] = beat / N;
          if (beat == N * NCAND - 1) exp_done[cyc + 5] = 1'b1;
        end
        beat++;
      end
      budget++;
      @(negedge clk);
    end
    ref_valid = 1'b0; cur_we = 1'b0; start = 1'b0;
    check("beats accepted within budget", beat, nbeats);
  endtask

  task automatic wait_done();
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (done) got = 1'b1;
      else @(negedge clk);
    end
    check("done reached", got, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset ref_ready", ref_ready, 0);
    check("reset sad_valid", sad_valid, 0);
    check("reset done", done, 0);
    check("reset sad", sad, 0);
    check("reset sad_idx", sad_idx, 0);
    check("reset best_sad", best_sad, BEST_INIT);
    check("reset best_idx", best_idx, 0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // cur 10 vs ref 13: 64 * 3
    fill_cur(10); fill_ref(13); write_block();
    run_search(0, 1'b0, N * NCAND);
    check("ref_ready low after final beat", ref_ready, 0);
    wait_done();
    check("const 10/13 sad", sad, 192);
    check("const 10/13 sad_idx", sad_idx, 3);

    // full-scale difference
    fill_cur(0); fill_ref(255); write_block();
    run_search(0, 1'b0, N * NCAND);
    wait_done();
    check("full-scale sad", sad, 16320);

    // distinct candidate SADs with a tie
    fill_cur(0); write_block();
    fill_ref_target(0, 300); fill_ref_target(1, 200);
    fill_ref_target(2, 200); fill_ref_target(3, 500);
    run_search(0, 1'b0, N * NCAND);
    wait_done();
    check("target last sad", sad, 500);
`ifdef SAD_MIN_TRACK_EN
    check("target best_sad", best_sad, 200);
    check("target best_idx", best_idx, 1);
`else
    check("target best_sad tied", best_sad, 0);
    check("target best_idx tied", best_idx, 0);
`endif

    // random pixels, both difference signs
    for (int r = 0; r < N; r++) for (int p = 0; p < N; p++) cur_px[r][p] = $urandom_range(0, 255);
    for (int c = 0; c < NCAND; c++)
      for (int r = 0; r < N; r++) for (int p = 0; p < N; p++) ref_px[c][r][p] = $urandom_range(0, 255);
    write_block();
    run_search(0, 1'b0, N * NCAND);
    wait_done();

    // alternating ref_valid
    fill_cur(1); fill_ref(0); write_block();
    run_search(1, 1'b0, N * NCAND);
    check("gapped ref_ready low after final beat", ref_ready, 0);
    wait_done();
    check("gapped sad", sad, 64);

    // abort with reset after five beats; storage must read back as zero
    fill_cur(6); fill_ref(6); write_block();
    run_search(0, 1'b0, 5);
    rst = 1'b1;
    exp_rst[cyc + 1] = 1'b1;
    exp_sad.delete(); exp_idx.delete(); exp_done.delete();
    @(negedge clk);
    rst = 1'b0;
    check("abort ref_ready", ref_ready, 0);
    check("abort sad_valid", sad_valid, 0);
    check("abort done", done, 0);
    for (int r = 0; r < N; r++) for (int p = 0; p < N; p++) cur_model[r][p] = 0;
    repeat (4) @(negedge clk);
    fill_ref(5);
    run_search(0, 1'b0, N * NCAND);
    wait_done();
    check("cleared storage sad", sad, 320);
    fill_cur(3); fill_ref(7); write_block();
    run_search(0, 1'b0, N * NCAND);
    wait_done();
    check("reloaded sad", sad, 256);

    // cur_we and start during RUN are ignored
    fill_cur(2); fill_ref(9); write_block();
    run_search(0, 1'b1, N * NCAND);
    wait_done();
    check("ignored writes sad", sad, 448);
    check("ignored writes sad_idx", sad_idx, 3);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
